branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Parametrised successor to the SAP-2 program counter and its single-condition jump path. It holds the program counter and resolves all conditional jumps (Z/NZ/C/NC/N/NN/always/never) from the ALU flags in one cycle. It adds a hardware CALL/RET return-address stack of configurable depth, with sticky overflow and underflow error flags. It sits between the microcode control unit, which drives the request strobes, and the memory address path, which consumes `counter_out`.

## Interface
- `ADDR_WIDTH`, 8: program counter and branch target width.
- `STACK_DEPTH`, 4: return-stack entries (≥1).
- `DEPTH_W`, $clog2(STACK_DEPTH+1): width of the occupancy count (derived).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_inc`  in  1  increment PC this cycle.
- `load_target`  in  1  conditional/unconditional jump request.
- `cond_sel`  in  3  condition code: 000 always, 001 Z, 010 NZ, 011 C, 100 NC, 101 N, 110 NN, 111 never.
- `target`  in  ADDR_WIDTH  jump/call destination.
- `flag_zero`, `flag_carry`, `flag_negative`  in  1 each  current ALU flags.
- `call_req`  in  1  push `counter_out`, then jump unconditionally to `target`.
- `ret_req`  in  1  pop the top of stack into the PC.
- `counter_out`  out  ADDR_WIDTH  registered program counter.
- `branch_taken`  out  1  one-cycle pulse: the PC was loaded by a jump, call or return.
- `stack_depth`  out  DEPTH_W  current number of stack entries.
- `stack_overflow`  out  1  sticky: a CALL was made with the stack full.
- `stack_underflow`  out  1  sticky: a RET was made with the stack empty.

## Operation
- Reset: `counter_out`=0, `stack_depth`=0, `branch_taken`=0, `stack_overflow`=0, `stack_underflow`=0.
  - Stack RAM contents are not reset and are never observable before a push.
- Request priority, one action per edge: reset > `ret_req` > `call_req` > `load_target` > `pc_inc` > hold.
  - A lower-priority request asserted at the same time as a higher one is ignored entirely (no side effects).
- Condition evaluation:
  - `cond_met` is computed combinationally from `cond_sel` and the flags sampled in the same cycle as `load_target`.
  - Code 111 is never met.
- `load_target` with `cond_met`=1: PC ← `target`; `branch_taken` pulses.
- `load_target` with `cond_met`=0:
  - If `pc_inc` is also high, PC ← PC+1. This is the not-taken fall-through, so the microcode can combine the operand-skip increment with the jump step.
  - Otherwise PC holds.
  - `branch_taken` stays 0 in both cases.
- `pc_inc` alone: PC ← PC+1, modulo 2^ADDR_WIDTH (0xFF wraps to 0x00 at width 8).
- `call_req`:
  - Not full: stack[depth] ← `counter_out` (the microcode has already advanced this to the return address); depth+1; PC ← `target`; `branch_taken` pulses.
  - Full (depth == STACK_DEPTH): `stack_overflow` ← 1; PC, depth and stack are unchanged; no pulse.
- `ret_req`:
  - Not empty: PC ← stack[depth-1]; depth−1; `branch_taken` pulses.
  - Empty: `stack_underflow` ← 1; PC unchanged; no pulse.
- The overflow and underflow flags clear only on reset.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- Latency is one cycle: a request sampled at edge N is visible on `counter_out`, `stack_depth` and the flags after edge N.
- `branch_taken` is high for exactly the cycle following the loading edge. Back-to-back taken requests give consecutive pulses.
- A CALL immediately followed by a RET on the next cycle returns the just-pushed address. The write is visible the next cycle; no bypass is needed.
- Reset asserted mid-sequence (for example, during a nested call chain) takes effect at the next edge regardless of other inputs. The stack is logically emptied.
- Flags are consumed only in the cycle `load_target` is high. Flag changes in other cycles have no effect.

## Test plan
- Reset, then `pc_inc` ×3 → `counter_out`=0x03; assert `reset` with `pc_inc` high → 0x00 and all outputs at their reset values after the edge.
- Z-taken and Z-not-taken:
  - PC=0x01, Z=1, `load_target` with `cond_sel`=001, `target`=0x05 → PC=0x05 and `branch_taken`=1 for one cycle.
  - PC=0x06, Z=0, same request with `target`=0x09 and `pc_inc`=1 → PC=0x07, `branch_taken`=0.
- Condition sweep: for every `cond_sel` code 000–111, drive Z/C/N combinations 000, 111, 100, 010 and 001 with `target`=0xA5 → PC is 0xA5 exactly when the condition holds, otherwise unchanged.
- Wrap: PC=0xFF plus `pc_inc` → 0x00 with no error flag set.
- Nested calls:
  - CALLs from PCs 0x10, 0x20, 0x30, 0x40 → `stack_depth`=4.
  - A fifth CALL → `stack_overflow`=1 and PC unchanged.
  - Four RETs → PC sequence 0x40, 0x30, 0x20, 0x10.
  - A fifth RET → `stack_underflow`=1 and PC unchanged.
- Priority:
  - `ret_req` + `call_req` both high with depth 1 (top=0x22) → PC=0x22, depth 0, no push.
  - Taken `load_target` + `pc_inc` → PC=`target`.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// Request/response bundle between the microcode control unit (master)
// and the branch sequencer (slave).
interface branch_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH_W    = 3
);
  logic                  pc_inc;
  logic                  load_target;
  logic [2:0]            cond_sel;
  logic [ADDR_WIDTH-1:0] target;
  logic                  flag_zero;
  logic                  flag_carry;
  logic                  flag_negative;
  logic                  call_req;
  logic                  ret_req;
  logic [ADDR_WIDTH-1:0] counter_out;
  logic                  branch_taken;
  logic [DEPTH_W-1:0]    stack_depth;
  logic                  stack_overflow;
  logic                  stack_underflow;

  modport master (
    output pc_inc, load_target, cond_sel, target,
    output flag_zero, flag_carry, flag_negative, call_req, ret_req,
    input  counter_out, branch_taken, stack_depth, stack_overflow, stack_underflow
  );

  modport slave (
    input  pc_inc, load_target, cond_sel, target,
    input  flag_zero, flag_carry, flag_negative, call_req, ret_req,
    output counter_out, branch_taken, stack_depth, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/branch_sequencer.sv
// Program counter with single-cycle conditional jumps and a CALL/RET
// return-address stack with sticky overflow/underflow flags.
module branch_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  branch_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'b000,
    COND_Z      = 3'b001,
    COND_NZ     = 3'b010,
    COND_C      = 3'b011,
    COND_NC     = 3'b100,
    COND_N      = 3'b101,
    COND_NN     = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  taken_q, taken_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_en;
  logic                  cond_met;
  logic                  stack_full, stack_empty;
  logic [IDX_W-1:0]      wr_idx, top_idx;
  cond_e                 cond;

  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  assign cond        = cond_e'(bus.cond_sel);
  assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);
  assign wr_idx      = IDX_W'(depth_q);
  assign top_idx     = IDX_W'(depth_q - DEPTH_W'(1));

  always_comb begin
    cond_met = 1'b0;
    unique case (cond)
      COND_ALWAYS: cond_met = 1'b1;
      COND_Z:      cond_met = bus.flag_zero;
      COND_NZ:     cond_met = ~bus.flag_zero;
      COND_C:      cond_met = bus.flag_carry;
      COND_NC:     cond_met = ~bus.flag_carry;
      COND_N:      cond_met = bus.flag_negative;
      COND_NN:     cond_met = ~bus.flag_negative;
      COND_NEVER:  cond_met = 1'b0;
    endcase
  end

  // Strict priority ret > call > load > inc; a losing request has no side effects.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    taken_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (bus.ret_req) begin
      if (stack_empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d    = stack_q[top_idx];
        depth_d = depth_q - DEPTH_W'(1);
        taken_d = 1'b1;
      end
    end else if (bus.call_req) begin
      if (stack_full) begin
        ovf_d = 1'b1;
      end else begin
        push_en = 1'b1;
        pc_d    = bus.target;
        depth_d = depth_q + DEPTH_W'(1);
        taken_d = 1'b1;
      end
    end else if (bus.load_target) begin
      if (cond_met) begin
        pc_d    = bus.target;
        taken_d = 1'b1;
      end else if (bus.pc_inc) begin
        pc_d = pc_q + ADDR_WIDTH'(1);
      end
    end else if (bus.pc_inc) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      depth_q <= '0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is not reset; the occupancy count alone defines validity.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      stack_q[wr_idx] <= pc_q;
    end
  end

  assign bus.counter_out     = pc_q;
  assign bus.branch_taken    = taken_q;
  assign bus.stack_depth     = depth_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed test-plan sequences plus randomized traffic, checked against a
// queue-based reference model of the sequencer.
module tb_branch_sequencer;

  localparam int unsigned AW = 8;
  localparam int unsigned SD = 4;
  localparam int unsigned DW = $clog2(SD + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  branch_sequencer_if #(.ADDR_WIDTH(AW), .DEPTH_W(DW)) bif ();

  branch_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .DEPTH_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned m_pc;
  int unsigned m_stk[$];
  bit          m_taken;
  bit          m_ovf;
  bit          m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_holds(input int unsigned code, input bit z, input bit c, input bit n);
    case (code)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return c;
      4: return !c;
      5: return n;
      6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    int unsigned mask = (1 << AW) - 1;
    m_taken = 1'b0;
    if (reset) begin
      m_pc  = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_stk.delete();
    end else if (bif.ret_req) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else begin
        m_pc    = m_stk.pop_back();
        m_taken = 1'b1;
      end
    end else if (bif.call_req) begin
      if (m_stk.size() == SD) m_ovf = 1'b1;
      else begin
        m_stk.push_back(m_pc);
        m_pc    = int'(bif.target);
        m_taken = 1'b1;
      end
    end else if (bif.load_target) begin
      if (cond_holds(int'(bif.cond_sel), bif.flag_zero, bif.flag_carry, bif.flag_negative)) begin
        m_pc    = int'(bif.target);
        m_taken = 1'b1;
      end else if (bif.pc_inc) begin
        m_pc = (m_pc + 1) & mask;
      end
    end else if (bif.pc_inc) begin
      m_pc = (m_pc + 1) & mask;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "/pc"},    32'(bif.counter_out),     m_pc);
    check({tag, "/taken"}, 32'(bif.branch_taken),    32'(m_taken));
    check({tag, "/depth"}, 32'(bif.stack_depth),     m_stk.size());
    check({tag, "/ovf"},   32'(bif.stack_overflow),  32'(m_ovf));
    check({tag, "/unf"},   32'(bif.stack_underflow), 32'(m_unf));
  endtask

  task automatic idle();
    reset             = 1'b0;
    bif.pc_inc        = 1'b0;
    bif.load_target   = 1'b0;
    bif.cond_sel      = 3'b000;
    bif.target        = '0;
    bif.flag_zero     = 1'b0;
    bif.flag_carry    = 1'b0;
    bif.flag_negative = 1'b0;
    bif.call_req      = 1'b0;
    bif.ret_req       = 1'b0;
  endtask

  task automatic set_pc(input logic [AW-1:0] a);
    idle();
    bif.load_target = 1'b1;
    bif.target      = a;
    step("setpc");
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step("reset");
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] zcn [5];
    logic [AW-1:0] call_pcs [4];
    zcn      = '{3'b000, 3'b111, 3'b100, 3'b010, 3'b001};
    call_pcs = '{8'h10, 8'h20, 8'h30, 8'h40};

    do_reset();
    check("rst_pc", 32'(bif.counter_out), 32'h0);
    check("rst_depth", 32'(bif.stack_depth), 32'h0);

    repeat (3) begin
      bif.pc_inc = 1'b1;
      step("inc");
    end
    check("pc_x3", 32'(bif.counter_out), 32'h03);
    reset = 1'b1;
    bif.pc_inc = 1'b1;
    step("rst_inc");
    check("rst_inc_pc", 32'(bif.counter_out), 32'h00);
    idle();

    bif.pc_inc = 1'b1;
    step("to01");
    idle();
    bif.load_target = 1'b1;
    bif.cond_sel    = 3'b001;
    bif.target      = 8'h05;
    bif.flag_zero   = 1'b1;
    step("z_taken");
    check("z_taken_pc", 32'(bif.counter_out), 32'h05);
    check("z_taken_pulse", 32'(bif.branch_taken), 32'h1);
    idle();
    bif.flag_zero = 1'b1;
    step("pulse_end");
    check("pulse_one_cycle", 32'(bif.branch_taken), 32'h0);

    idle();
    bif.pc_inc = 1'b1;
    step("to06");
    idle();
    bif.load_target = 1'b1;
    bif.cond_sel    = 3'b001;
    bif.target      = 8'h09;
    bif.pc_inc      = 1'b1;
    step("z_not_taken");
    check("z_nt_pc", 32'(bif.counter_out), 32'h07);
    check("z_nt_pulse", 32'(bif.branch_taken), 32'h0);

    for (int unsigned code = 0; code < 8; code++) begin
      for (int unsigned k = 0; k < 5; k++) begin
        set_pc(8'h3C);
        bif.load_target   = 1'b1;
        bif.cond_sel      = 3'(code);
        bif.target        = 8'hA5;
        bif.flag_zero     = zcn[k][2];
        bif.flag_carry    = zcn[k][1];
        bif.flag_negative = zcn[k][0];
        step("sweep");
      end
    end

    set_pc(8'hFF);
    bif.pc_inc = 1'b1;
    step("wrap");
    check("wrap_pc", 32'(bif.counter_out), 32'h00);
    check("wrap_ovf", 32'(bif.stack_overflow), 32'h0);

    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      set_pc(call_pcs[i]);
      bif.call_req = 1'b1;
      bif.target   = call_pcs[i] + 8'h01;
      step("call");
    end
    check("nest_depth", 32'(bif.stack_depth), 32'd4);
    idle();
    bif.call_req = 1'b1;
    bif.target   = 8'h99;
    step("call_full");
    check("ovf_flag", 32'(bif.stack_overflow), 32'h1);
    check("ovf_pc", 32'(bif.counter_out), 32'h41);
    for (int i = 3; i >= 0; i--) begin
      idle();
      bif.ret_req = 1'b1;
      step("ret");
      check("ret_pc", 32'(bif.counter_out), 32'(call_pcs[i]));
    end
    idle();
    bif.ret_req = 1'b1;
    step("ret_empty");
    check("unf_flag", 32'(bif.stack_underflow), 32'h1);
    check("unf_pc", 32'(bif.counter_out), 32'h10);

    do_reset();
    set_pc(8'h22);
    bif.call_req = 1'b1;
    bif.target   = 8'h60;
    step("prio_call");
    idle();
    bif.ret_req  = 1'b1;
    bif.call_req = 1'b1;
    bif.target   = 8'h77;
    step("prio_ret_call");
    check("prio_rc_pc", 32'(bif.counter_out), 32'h22);
    check("prio_rc_depth", 32'(bif.stack_depth), 32'h0);
    idle();
    bif.load_target = 1'b1;
    bif.target      = 8'h5A;
    bif.pc_inc      = 1'b1;
    step("prio_load_inc");
    check("prio_li_pc", 32'(bif.counter_out), 32'h5A);

    repeat (600) begin
      reset             = ($urandom_range(0, 39) == 0);
      bif.pc_inc        = 1'($urandom_range(0, 1));
      bif.load_target   = ($urandom_range(0, 2) == 0);
      bif.cond_sel      = 3'($urandom_range(0, 7));
      bif.target        = AW'($urandom);
      bif.flag_zero     = 1'($urandom_range(0, 1));
      bif.flag_carry    = 1'($urandom_range(0, 1));
      bif.flag_negative = 1'($urandom_range(0, 1));
      bif.call_req      = ($urandom_range(0, 4) == 0);
      bif.ret_req       = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
